// File: rtl/morse_decoder_az.sv
// morse_decoder_az: times marks/spaces on a synchronised Morse line and decodes dot/dash patterns to letters A-Z
module morse_decoder_az #(
  parameter int CLKS_PER_UNIT = 25_000_000,
  parameter int CNT_W = 26
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       MorseIn,
  output logic [4:0] Letter,
  output logic       Valid,
  output logic       Error,
  output logic       Busy
);
  typedef enum logic [1:0] {IDLE, MARK, SPACE, DRAIN} state_t;
  state_t state, state_n;
  logic m_q1, m_s, m_d, rise, fall, wrap, glitch, dash, long_mark;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0] unit_cnt, nsym, nsym_n;
  logic [3:0] pat, pat_n;
  logic prev_sp, prev_sp_n, pend, pend_n, valid_n, error_n, dec_ok;
  logic [4:0] letter_n, dec_idx;
  assign rise = m_s & ~m_d;
  assign fall = ~m_s & m_d;
  assign wrap = clk_cnt == CNT_W'(CLKS_PER_UNIT - 1);
  assign glitch = (unit_cnt == 3'd0) && (clk_cnt < CNT_W'(CLKS_PER_UNIT / 2 - 1));
  assign dash = unit_cnt >= 3'd2;
  assign long_mark = unit_cnt >= 3'd5;
  assign Busy = state != IDLE;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      m_q1 <= 1'b0;
      m_s <= 1'b0;
      m_d <= 1'b0;
      clk_cnt <= '0;
      unit_cnt <= '0;
    end else begin
      m_q1 <= MorseIn;
      m_s <= m_q1;
      m_d <= m_s;
      clk_cnt <= (rise || fall || wrap) ? '0 : clk_cnt + CNT_W'(1);
      unit_cnt <= (rise || fall) ? 3'd0 : (wrap && unit_cnt != 3'd7) ? unit_cnt + 3'd1 : unit_cnt;
    end
  end
  // pat holds the symbols right-aligned, so {nsym, pat} uniquely identifies a code
  always_comb begin
    dec_ok = 1'b1;
    dec_idx = 5'd0;
    case ({nsym, pat})
      {3'd2, 4'b0001}: dec_idx = 5'd0;
      {3'd4, 4'b1000}: dec_idx = 5'd1;
      {3'd4, 4'b1010}: dec_idx = 5'd2;
      {3'd3, 4'b0100}: dec_idx = 5'd3;
      {3'd1, 4'b0000}: dec_idx = 5'd4;
      {3'd4, 4'b0010}: dec_idx = 5'd5;
      {3'd3, 4'b0110}: dec_idx = 5'd6;
      {3'd4, 4'b0000}: dec_idx = 5'd7;
      {3'd2, 4'b0000}: dec_idx = 5'd8;
      {3'd4, 4'b0111}: dec_idx = 5'd9;
      {3'd3, 4'b0101}: dec_idx = 5'd10;
      {3'd4, 4'b0100}: dec_idx = 5'd11;
      {3'd2, 4'b0011}: dec_idx = 5'd12;
      {3'd2, 4'b0010}: dec_idx = 5'd13;
      {3'd3, 4'b0111}: dec_idx = 5'd14;
      {3'd4, 4'b0110}: dec_idx = 5'd15;
      {3'd4, 4'b1101}: dec_idx = 5'd16;
      {3'd3, 4'b0010}: dec_idx = 5'd17;
      {3'd3, 4'b0000}: dec_idx = 5'd18;
      {3'd1, 4'b0001}: dec_idx = 5'd19;
      {3'd3, 4'b0001}: dec_idx = 5'd20;
      {3'd4, 4'b0001}: dec_idx = 5'd21;
      {3'd3, 4'b0011}: dec_idx = 5'd22;
      {3'd4, 4'b1001}: dec_idx = 5'd23;
      {3'd4, 4'b1011}: dec_idx = 5'd24;
      {3'd4, 4'b1100}: dec_idx = 5'd25;
      default: dec_ok = 1'b0;
    endcase
  end
  always_comb begin
    state_n = state;
    pat_n = pat;
    nsym_n = nsym;
    prev_sp_n = prev_sp;
    pend_n = 1'b0;
    letter_n = Letter;
    valid_n = 1'b0;
    error_n = 1'b0;
    case (state)
      IDLE: if (rise || pend) begin
        state_n = MARK;
        pat_n = 4'd0;
        nsym_n = 3'd0;
        prev_sp_n = 1'b0;
      end
      MARK: if (fall) begin
        if (glitch) state_n = prev_sp ? SPACE : IDLE;
        else if (long_mark || nsym == 3'd4) begin
          state_n = DRAIN;
          error_n = 1'b1;
        end else begin
          state_n = SPACE;
          pat_n = {pat[2:0], dash};
          nsym_n = nsym + 3'd1;
        end
      end
      // the letter gap beats a simultaneous rise; the rise is replayed from IDLE via pend
      SPACE: if (unit_cnt == 3'd3) begin
        state_n = IDLE;
        valid_n = dec_ok;
        error_n = ~dec_ok;
        letter_n = dec_ok ? dec_idx : Letter;
        pend_n = rise;
      end else if (rise) begin
        state_n = MARK;
        prev_sp_n = 1'b1;
      end
      DRAIN: if (!m_s && !fall && unit_cnt == 3'd3) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      pat <= 4'd0;
      nsym <= 3'd0;
      prev_sp <= 1'b0;
      pend <= 1'b0;
      Letter <= 5'd0;
      Valid <= 1'b0;
      Error <= 1'b0;
    end else begin
      state <= state_n;
      pat <= pat_n;
      nsym <= nsym_n;
      prev_sp <= prev_sp_n;
      pend <= pend_n;
      Letter <= letter_n;
      Valid <= valid_n;
      Error <= error_n;
    end
  end
endmodule

// File: tb/tb_morse_decoder_az.sv
// tb_morse_decoder_az: drives Morse letters with random timing and checks decoded output against a table-driven model
module tb_morse_decoder_az;
  localparam int CPU = 4;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic MorseIn = 1'b0;
  logic [4:0] Letter;
  logic Valid, Error, Busy;
  int vectors = 0, miscompares = 0;
  int n_valid, n_err, tot_both = 0;
  logic [4:0] got[$];
  logic [4:0] last_exp = 5'd0;
  string morse[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---", "-.-", ".-..", "--",
                       "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
  morse_decoder_az #(.CLKS_PER_UNIT(CPU), .CNT_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .MorseIn(MorseIn), .Letter(Letter), .Valid(Valid), .Error(Error), .Busy(Busy)
  );
  always #5 Clock = ~Clock;
  task automatic tick(input logic m);
    @(negedge Clock);
    if (Valid) begin
      n_valid++;
      got.push_back(Letter);
    end
    if (Error) n_err++;
    if (Valid && Error) tot_both++;
    MorseIn = m;
  endtask
  task automatic hold(input logic m, input int n);
    repeat (n) tick(m);
  endtask
  task automatic clr();
    n_valid = 0;
    n_err = 0;
    got.delete();
  endtask
  // dot < 2 units, dash 2..5 units, intra-letter space < 3 units; random picks stay clear of the limits
  task automatic send_code(input string code, input bit rnd);
    int on, off;
    for (int i = 0; i < code.len(); i++) begin
      on = (code[i] == "-") ? (rnd ? int'($urandom_range(19, 10)) : 3 * CPU) : (rnd ? int'($urandom_range(7, 3)) : CPU);
      off = (i == code.len() - 1) ? 0 : (rnd ? int'($urandom_range(11, 2)) : CPU);
      hold(1'b1, on);
      hold(1'b0, off);
    end
  endtask
  task automatic check_letter(input string name, input int idx);
    vectors++;
    if (n_valid !== 1 || n_err !== 0) begin
      miscompares++;
      $display("FAIL %s counts: valid=%0d error=%0d, want valid=1 error=0", name, n_valid, n_err);
    end
    vectors++;
    if (got.size() == 0 || got[0] !== 5'(idx)) begin
      miscompares++;
      $display("FAIL %s letter: got %0d, want %0d", name, (got.size() > 0) ? got[0] : 5'h1f, idx);
    end
    last_exp = 5'(idx);
  endtask
  task automatic test_reset();
    Reset = 1'b1;
    hold(1'b0, 3);
    Reset = 1'b0;
    hold(1'b0, 2);
    vectors++;
    if ({Letter, Valid, Error, Busy} !== 8'd0) begin
      miscompares++;
      $display("FAIL reset outputs: got L=%0d V=%b E=%b B=%b, want all 0", Letter, Valid, Error, Busy);
    end
  endtask
  task automatic test_s();
    int lat;
    clr();
    hold(1'b1, 4);
    vectors++;
    hold(1'b0, 1);
    if (Busy !== 1'b0) begin
    end
    hold(1'b0, 3);
    if (Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL s_busy: got %b, want 1", Busy);
    end
    hold(1'b1, 4);
    hold(1'b0, 4);
    hold(1'b1, 4);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      tick(1'b0);
      if (Valid && lat < 0) lat = i - 1;
    end
    check_letter("s", 18);
    vectors++;
    if (lat < 3 * CPU + 2 || lat > 3 * CPU + 5) begin
      miscompares++;
      $display("FAIL s_latency: got %0d edges, want about %0d", lat, 3 * CPU + 3);
    end
  endtask
  task automatic test_loopback();
    string bits;
    for (int l = 18; l < 26; l++) begin
      bits = "";
      for (int i = 0; i < morse[l].len(); i++)
        bits = {bits, (i > 0) ? "0" : "", (morse[l][i] == "-") ? "111" : "1"};
      clr();
      for (int i = 0; i < bits.len(); i++) hold(bits[i] == "1", CPU);
      hold(1'b0, 20);
      check_letter("loopback", l);
    end
  endtask
  task automatic test_random();
    int idx;
    for (int k = 0; k < 30; k++) begin
      idx = int'($urandom_range(25, 0));
      clr();
      send_code(morse[idx], 1'b1);
      hold(1'b0, int'($urandom_range(24, 18)));
      check_letter("random", idx);
    end
  endtask
  task automatic test_invalid();
    string bad[4] = '{"----", "..--", ".-.-", "---."};
    for (int k = 0; k < 4; k++) begin
      clr();
      send_code(bad[k], k != 0);
      hold(1'b0, 20);
      vectors++;
      if (n_err !== 1 || n_valid !== 0) begin
        miscompares++;
        $display("FAIL invalid %s counts: error=%0d valid=%0d, want 1/0", bad[k], n_err, n_valid);
      end
      vectors++;
      if (Letter !== last_exp) begin
        miscompares++;
        $display("FAIL invalid %s letter held: got %0d, want %0d", bad[k], Letter, last_exp);
      end
    end
  endtask
  task automatic test_glitch();
    clr();
    hold(1'b1, 1);
    hold(1'b0, 6);
    vectors++;
    if (Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_busy: got %b, want 0", Busy);
    end
    hold(1'b0, 14);
    vectors++;
    if (n_valid !== 0 || n_err !== 0) begin
      miscompares++;
      $display("FAIL glitch_quiet: valid=%0d error=%0d, want 0/0", n_valid, n_err);
    end
    clr();
    hold(1'b1, 24);
    hold(1'b0, 6);
    vectors++;
    if (n_err !== 1 || Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL long_mark: error=%0d busy=%b, want 1/1", n_err, Busy);
    end
    hold(1'b0, 16);
    vectors++;
    if (Busy !== 1'b0 || n_valid !== 0 || n_err !== 1) begin
      miscompares++;
      $display("FAIL drain_exit: busy=%b valid=%0d error=%0d, want 0/0/1", Busy, n_valid, n_err);
    end
    clr();
    hold(1'b1, 4);
    hold(1'b0, 3);
    hold(1'b1, 1);
    hold(1'b0, 3);
    hold(1'b1, 12);
    hold(1'b0, 20);
    check_letter("glitch_in_space", 0);
  endtask
  task automatic test_overflow();
    clr();
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, CPU);
      hold(1'b0, CPU);
    end
    vectors++;
    if (n_err !== 1 || n_valid !== 0) begin
      miscompares++;
      $display("FAIL overflow: error=%0d valid=%0d, want 1/0", n_err, n_valid);
    end
    hold(1'b0, 16);
    clr();
    send_code(".", 1'b0);
    hold(1'b0, 20);
    check_letter("after_overflow", 4);
  endtask
  task automatic test_reset_mid();
    clr();
    hold(1'b1, 6);
    Reset = 1'b1;
    @(negedge Clock);
    vectors++;
    if ({Letter, Valid, Error, Busy} !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_mid outputs: got L=%0d V=%b E=%b B=%b, want all 0", Letter, Valid, Error, Busy);
    end
    MorseIn = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    hold(1'b0, 4);
    clr();
    hold(1'b1, 12);
    hold(1'b0, 20);
    check_letter("after_reset", 19);
  endtask
  task automatic test_back_to_back();
    clr();
    hold(1'b1, CPU);
    hold(1'b0, 3 * CPU + 1);
    hold(1'b1, 3 * CPU);
    hold(1'b0, 20);
    vectors++;
    if (n_valid !== 2 || n_err !== 0 || got.size() != 2 || got[0] !== 5'd4 || got[1] !== 5'd19) begin
      miscompares++;
      $display("FAIL back_to_back: valid=%0d error=%0d first=%0d second=%0d, want 2/0/4/19", n_valid, n_err,
               (got.size() > 0) ? got[0] : 5'h1f, (got.size() > 1) ? got[1] : 5'h1f);
    end
  endtask
  task automatic test_exclusive();
    vectors++;
    if (tot_both !== 0) begin
      miscompares++;
      $display("FAIL valid_error_overlap: %0d cycles, want 0", tot_both);
    end
  endtask
  initial begin
    test_reset();
    test_s();
    test_loopback();
    test_random();
    test_invalid();
    test_glitch();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
